div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_div_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_scheduler.sv
// -----------------------------------------------------------------------------
// div_scheduler
//
// Purpose:
//   Shares one sequential divider (LA/EB/s/Done handshake style) between two
//   requesters. A round-robin arbiter accepts one request at a time. The
//   operands are loaded into the divider, and the block waits for Done. It
//   then captures Q/R and presents them on a shared response bus. The bus is
//   qualified by a one-hot rsp_valid, and it is held until the selected
//   requester takes the response.
//
// Optional feature (compile-time macro):
//   DIV_ZERO_BYPASS_EN - when defined, a request with b == 0 skips the divider.
//                        It is answered directly with q = all ones, r = a and
//                        rsp_dz = 1. When undefined, b == 0 is sequenced
//                        through the divider, and rsp_dz is tied to 0.
//
// Parameters:
//   N          operand / result width; must match the divider's width
//
// Ports:
//   Clock      in   1   rising-edge clock
//   Resetn     in   1   asynchronous active-low reset
//   req_valid  in   2   request valid, bit i = requester i
//   req_ready  out  2   one-hot grant (only while idle)
//   req_a0/b0  in   N   dividend / divisor of requester 0
//   req_a1/b1  in   N   dividend / divisor of requester 1
//   rsp_valid  out  2   response valid, bit i = requester i (one-hot)
//   rsp_ready  in   2   response accept, only the selected bit is honoured
//   rsp_q      out  N   quotient
//   rsp_r      out  N   remainder
//   rsp_dz     out  1   divide-by-zero flag
//   div_LA     out  1   divider: load dividend
//   div_EB     out  1   divider: load divisor
//   div_s      out  1   divider: start / run
//   div_DataA  out  N   divider: dividend (non-zero only during LOAD)
//   div_DataB  out  N   divider: divisor  (non-zero only during LOAD)
//   div_Q      in   N   divider: quotient
//   div_R      in   N   divider: remainder
//   div_Done   in   1   divider: operation complete
// -----------------------------------------------------------------------------
module div_scheduler #(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Resetn,

    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] req_a0,
    input  logic [N-1:0] req_b0,
    input  logic [N-1:0] req_a1,
    input  logic [N-1:0] req_b1,

    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_q,
    output logic [N-1:0] rsp_r,
    output logic         rsp_dz,

    output logic         div_LA,
    output logic         div_EB,
    output logic         div_s,
    output logic [N-1:0] div_DataA,
    output logic [N-1:0] div_DataB,
    input  logic [N-1:0] div_Q,
    input  logic [N-1:0] div_R,
    input  logic         div_Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Goes high on the first clock after reset is released. Grants are held
    // off until then, so req_ready stays 0 for the whole reset window. This
    // avoids routing Resetn into the combinational grant path.
    logic armed_q;

    // Requester served most recently. It resets to 1 so that requester 0
    // wins the first contention.
    logic last_q;

    // Latched request
    logic         sel_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;

    // Response registers
    logic [N-1:0] quot_q;
    logic [N-1:0] rem_q;
`ifdef DIV_ZERO_BYPASS_EN
    logic         dz_q;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0]   grant;
    logic         accept;
    logic         acc_idx;
    logic [N-1:0] acc_a;
    logic [N-1:0] acc_b;
    logic         acc_bypass;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;  // the one not served last
            default: grant = 2'b00;
        endcase
    end

    assign accept  = |(req_valid & req_ready);
    assign acc_idx = req_ready[1];
    assign acc_a   = acc_idx ? req_a1 : req_a0;
    assign acc_b   = acc_idx ? req_b1 : req_b0;

`ifdef DIV_ZERO_BYPASS_EN
    assign acc_bypass = (acc_b == '0);
`else
    assign acc_bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = acc_bypass ? RESP : LOAD;
                end
            end
            LOAD:  state_d = RUN;
            RUN: begin
                if (div_Done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = RESP;
            RESP: begin
                // Only the selected requester's rsp_ready completes the response.
                if (rsp_ready[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        div_LA    = 1'b0;
        div_EB    = 1'b0;
        div_s     = 1'b0;
        div_DataA = '0;
        div_DataB = '0;
        case (state_q)
            IDLE: begin
                if (armed_q) begin
                    req_ready = grant;
                end
            end
            LOAD: begin
                div_LA    = 1'b1;
                div_EB    = 1'b1;
                div_DataA = a_q;
                div_DataB = b_q;
            end
            RUN: begin
                div_s = 1'b1;
            end
            DRAIN: begin
                // s drops for this cycle, which returns the divider to idle.
            end
            RESP: begin
                rsp_valid = sel_q ? 2'b10 : 2'b01;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            armed_q <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            armed_q <= 1'b1;
            if (state_q == IDLE && accept) begin
                sel_q  <= acc_idx;
                last_q <= acc_idx;
                a_q    <= acc_a;
                b_q    <= acc_b;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            if (state_q == DRAIN) begin
                quot_q <= div_Q;
                rem_q  <= div_R;
            end else if (state_q == IDLE && accept && acc_bypass) begin
                quot_q <= '1;
                rem_q  <= acc_a;
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            dz_q <= 1'b0;
        end else begin
            if (state_q == DRAIN) begin
                dz_q <= 1'b0;
            end else if (state_q == IDLE && accept) begin
                dz_q <= acc_bypass;
            end
        end
    end

    assign rsp_dz = dz_q;
`else
    assign rsp_dz = 1'b0;
`endif

    assign rsp_q = quot_q;
    assign rsp_r = rem_q;

endmodule

// File: tb/tb_div_scheduler.sv
// -----------------------------------------------------------------------------
// tb_div_scheduler
//
// Self-checking bench for div_scheduler. The shared divider is modelled
// behaviourally: it loads operands on LA/EB and finishes after a random
// latency while s is held. Expected results come from plain arithmetic
// (q = a / b, r = a % b). The expected arbitration winner comes from a
// "who was served last" variable.
// -----------------------------------------------------------------------------
module tb_div_scheduler;

    localparam int N = 8;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [N-1:0] rsp_q, rsp_r;
    logic         rsp_dz;
    logic         div_LA, div_EB, div_s;
    logic [N-1:0] div_DataA, div_DataB;
    logic [N-1:0] div_Q, div_R;
    logic         div_Done;

    int checks = 0;
    int errors = 0;
    int last_served;

    always #5 Clock = ~Clock;

    div_scheduler #(.N(N)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dz    (rsp_dz),
        .div_LA    (div_LA),
        .div_EB    (div_EB),
        .div_s     (div_s),
        .div_DataA (div_DataA),
        .div_DataB (div_DataB),
        .div_Q     (div_Q),
        .div_R     (div_R),
        .div_Done  (div_Done)
    );

    // Behavioural divider with random latency of 1..N cycles of s
    logic [N-1:0] dA = '0;
    logic [N-1:0] dB = '0;
    int           dcnt = 3;

    always @(posedge Clock) begin
        if (div_LA && div_EB) begin
            dA <= div_DataA;
            dB <= div_DataB;
        end
        if (!div_s) begin
            dcnt <= int'($urandom_range(1, N));
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    end

    assign div_Done = div_s && (dcnt == 0);
    assign div_Q    = (dB == '0) ? {N{1'b1}} : dA / dB;
    assign div_R    = (dB == '0) ? dA : dA % dB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nstep();
        @(negedge Clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 0);
        chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 0);
        chk({tag, "_ctrl"}, {29'd0, div_LA, div_EB, div_s}, 0);
        chk({tag, "_data"}, {16'd0, div_DataA, div_DataB}, 0);
        chk({tag, "_rsp"}, {15'd0, rsp_q, rsp_r, rsp_dz}, 0);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) begin
            nstep();
            chk("reset_hold_rsp_valid", {30'd0, rsp_valid}, 0);
        end
        Resetn = 1'b1;
        last_served = 1;
    endtask

    // Serve one request from port p (p is the expected arbitration winner).
    // hold = cycles rsp_ready[p] is withheld after rsp_valid rises (0 = held high).
    // raise_other raises the other port's valid right after acceptance.
    task automatic serve(input int p, input int hold, input bit raise_other);
        int           k, la_cnt, s_cnt;
        logic [N-1:0] ea, eb, eq, er;
        logic [1:0]   pm;
        bit           byp;
        pm = (p == 1) ? 2'b10 : 2'b01;
        if (hold == 0) rsp_ready[p] = 1'b1;
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 50) begin
            nstep();
            k++;
        end
        chk("grant_wait", {31'd0, k < 50}, 1);
        chk("grant", {30'd0, req_ready}, {30'd0, pm});
        ea  = (p == 1) ? req_a1 : req_a0;
        eb  = (p == 1) ? req_b1 : req_b0;
        byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        byp = (eb == '0);
`endif
        eq  = (eb == '0) ? {N{1'b1}} : ea / eb;
        er  = (eb == '0) ? ea : ea % eb;
        last_served = p;
        nstep();
        req_valid[p] = 1'b0;
        if (raise_other) req_valid[1-p] = 1'b1;
        #1;
        la_cnt = 0;
        s_cnt  = 0;
        k      = 0;
        while (rsp_valid == 2'b00 && k < 300) begin
            chk("busy_req_ready", {30'd0, req_ready}, 0);
            if (div_LA) begin
                chk("load_dataA", {24'd0, div_DataA}, {24'd0, ea});
                chk("load_dataB", {24'd0, div_DataB}, {24'd0, eb});
                chk("load_eb_s", {30'd0, div_EB, div_s}, 2'b10);
            end else begin
                chk("data_idle", {16'd0, div_DataA, div_DataB}, 0);
            end
            la_cnt += int'(div_LA);
            s_cnt  += int'(div_s);
            nstep();
            k++;
        end
        chk("rsp_wait", {31'd0, k < 300}, 1);
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, pm});
        chk("rsp_q", {24'd0, rsp_q}, {24'd0, eq});
        chk("rsp_r", {24'd0, rsp_r}, {24'd0, er});
        chk("rsp_dz", {31'd0, rsp_dz}, {31'd0, byp});
        chk("la_pulses", la_cnt, byp ? 0 : 1);
        chk("s_active", {31'd0, s_cnt > 0}, {31'd0, !byp});
        for (int i = 0; i < hold; i++) begin
            rsp_ready[1-p] = 1'b1;
            nstep();
            chk("hold_rsp_valid", {30'd0, rsp_valid}, {30'd0, pm});
            chk("hold_rsp_q", {24'd0, rsp_q}, {24'd0, eq});
            chk("hold_rsp_r", {24'd0, rsp_r}, {24'd0, er});
            chk("hold_req_ready", {30'd0, req_ready}, 0);
        end
        rsp_ready[1-p] = 1'b0;
        rsp_ready[p]   = 1'b1;
        nstep();
        chk("rsp_done", {30'd0, rsp_valid}, 0);
        rsp_ready[p] = 1'b0;
        $display("txn port=%0d a=%0d b=%0d q=%0d r=%0d dz=%0d hold=%0d", p, ea, eb, rsp_q, rsp_r, rsp_dz, hold);
    endtask

    initial begin
        int k, r, w, hold;
        Resetn    = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        last_served = 1;

        // Reset state; a request during reset is not granted
        #2;
        req_valid = 2'b11;
        do_reset();
        req_valid = 2'b00;

        // Requester 0: 30 / 6 with rsp_ready held high
        req_a0 = 8'd30; req_b0 = 8'd6; req_valid[0] = 1'b1;
        serve(0, 0, 1'b0);

        // Requester 1: 120 / 16
        req_a1 = 8'd120; req_b1 = 8'd16; req_valid[1] = 1'b1;
        serve(1, 0, 1'b0);

        // Contention from reset: port 0 first, then a repeat contention favours port 1
        do_reset();
        req_a0 = 8'd50; req_b0 = 8'd6; req_a1 = 8'd200; req_b1 = 8'd7;
        req_valid = 2'b11;
        serve(0, 0, 1'b0);
        req_valid[0] = 1'b1;
        serve(1, 0, 1'b0);
        serve(0, 0, 1'b0);

        // Backpressure: rsp_ready[0] withheld 10 cycles while requester 1 waits
        req_a0 = 8'd100; req_b0 = 8'd9; req_a1 = 8'd13; req_b1 = 8'd5;
        req_valid[0] = 1'b1;
        serve(0, 10, 1'b1);
        serve(1, 0, 1'b0);

        // Divide by zero
        req_a0 = 8'd77; req_b0 = 8'd0; req_valid[0] = 1'b1;
        serve(0, 0, 1'b0);

        // Reset during RUN aborts the operation
        req_a0 = 8'd30; req_b0 = 8'd6; req_valid[0] = 1'b1;
        #1;
        k = 0;
        while (!div_s && k < 50) begin
            nstep();
            k++;
        end
        chk("run_reached", {31'd0, div_s}, 1);
        req_valid = 2'b00;
        do_reset();
        repeat (3) begin
            nstep();
            chk("post_reset_no_rsp", {30'd0, rsp_valid}, 0);
        end
        req_valid[0] = 1'b1;
        serve(0, 0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            r    = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            req_a0 = N'($urandom);
            req_a1 = N'($urandom);
            req_b0 = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            req_b1 = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            if (r == 3) begin
                req_valid = 2'b11;
                w = 1 - last_served;
                serve(w, hold, 1'b0);
                serve(1 - w, 0, 1'b0);
            end else begin
                req_valid[r & 1] = 1'b1;
                serve(r & 1, hold, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
